conv_mult_sched: RTL and testbench

- Scheduler that drives the CONV multiplier array for one layer pass.
- Per output pixel it iterates every output-channel group (og, outer loop) and every input-channel group (ig, inner loop).
- It issues weight-memory reads, the multiplier enable and the line-buffer channel-group select and pop.
- It emits accumulator tags aligned with the multiplier array's registered output.

---
 rtl/conv_mult_sched.sv | 236 +++++++++++++++++++++++
 tb/tb_conv_mult_sched.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mult_sched.sv
// conv_mult_sched: schedules the CONV multiplier array for one layer pass.
// For each output pixel it walks every output-channel group (og, outer) and
// every input-channel group (ig, inner), issuing one weight read per op,
// enabling the multiplier array one cycle later and emitting accumulator
// tags aligned with the array's registered output.
//
// Optional feature macro: CONV_MULT_SCHED_PERF_EN (adds perf_busy_cyc and
// perf_stall_cyc counters).
//
// Ports:
//   clk, rst (async, active-high)
//   start, cfg_num_ig, cfg_num_og, cfg_num_pix : pass control/configuration
//   busy, done                                  : pass status
//   win_valid / win_pop, fm_grp_sel             : line buffer handshake/select
//   w_rd_en, w_addr                             : weight memory read (1-cycle latency)
//   mult_array_en                               : multiplier array enable
//   acc_stall                                   : accumulator backpressure (gates issue only)
//   tag_valid, acc_first, acc_last, acc_og, acc_pix_last : accumulator tags
//   perf_busy_cyc, perf_stall_cyc               : only with CONV_MULT_SCHED_PERF_EN
module conv_mult_sched #(
    parameter int PIPELINE_STAGE = 1,
    parameter int IG_W           = 8,
    parameter int OG_W           = 8,
    parameter int PIX_W          = 16,
    parameter int ADDR_W         = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [IG_W-1:0]   cfg_num_ig,
    input  logic [OG_W-1:0]   cfg_num_og,
    input  logic [PIX_W-1:0]  cfg_num_pix,
    output logic              busy,
    output logic              done,
    input  logic              win_valid,
    output logic              win_pop,
    output logic [IG_W-1:0]   fm_grp_sel,
    output logic              w_rd_en,
    output logic [ADDR_W-1:0] w_addr,
    output logic              mult_array_en,
    input  logic              acc_stall,
    output logic              tag_valid,
    output logic              acc_first,
    output logic              acc_last,
    output logic [OG_W-1:0]   acc_og,
    output logic              acc_pix_last
`ifdef CONV_MULT_SCHED_PERF_EN
    ,
    output logic [31:0]       perf_busy_cyc,
    output logic [31:0]       perf_stall_cyc
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Tag pipe: stage 0 is visible at t+1, stage PIPELINE_STAGE at t+1+PIPELINE_STAGE.
    localparam int DEPTH = PIPELINE_STAGE + 1;
    localparam int TAG_W = OG_W + 3;
    localparam int DC_W  = $clog2(PIPELINE_STAGE + 1);

    logic [1:0]        r_state;
    logic [IG_W-1:0]   r_num_ig;
    logic [OG_W-1:0]   r_num_og;
    logic [PIX_W-1:0]  r_num_pix;
    logic [IG_W-1:0]   r_ig;
    logic [OG_W-1:0]   r_og;
    logic [PIX_W-1:0]  r_pix;
    logic [ADDR_W-1:0] r_op;
    logic [DC_W-1:0]   r_drain_cnt;
    logic              r_mult_en;
    logic [IG_W-1:0]   r_fm_sel;
    logic              r_win_pop;
    logic              r_tag_vld [DEPTH];
    logic [TAG_W-1:0]  r_tag_dat [DEPTH];

    logic w_issue;
    logic w_ig_wrap;
    logic w_og_wrap;
    logic w_pix_last;
    logic w_cfg_zero;
    logic [TAG_W-1:0] w_tag_new;

    assign w_issue    = (r_state == S_RUN) && win_valid && !acc_stall;
    assign w_ig_wrap  = (r_ig  == (r_num_ig  - IG_W'(1)));
    assign w_og_wrap  = (r_og  == (r_num_og  - OG_W'(1)));
    assign w_pix_last = (r_pix == (r_num_pix - PIX_W'(1)));
    assign w_cfg_zero = (cfg_num_ig == {IG_W{1'b0}}) || (cfg_num_og == {OG_W{1'b0}})
                     || (cfg_num_pix == {PIX_W{1'b0}});
    // Tag layout: {first, last, pix_last, og}; zeroed on bubble cycles.
    assign w_tag_new  = w_issue ? {(r_ig == {IG_W{1'b0}}), w_ig_wrap, w_pix_last, r_og}
                                : {TAG_W{1'b0}};

    // Pass FSM and configuration latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_num_ig    <= {IG_W{1'b0}};
            r_num_og    <= {OG_W{1'b0}};
            r_num_pix   <= {PIX_W{1'b0}};
            r_drain_cnt <= {DC_W{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_num_ig  <= cfg_num_ig;
                        r_num_og  <= cfg_num_og;
                        r_num_pix <= cfg_num_pix;
                        r_state   <= w_cfg_zero ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_issue && w_ig_wrap && w_og_wrap && w_pix_last) begin
                        r_state     <= S_DRAIN;
                        r_drain_cnt <= DC_W'(PIPELINE_STAGE);
                    end
                end
                S_DRAIN: begin
                    // Holds PIPELINE_STAGE+1 cycles: last tag leaves the pipe before DONE.
                    if (r_drain_cnt == {DC_W{1'b0}}) begin
                        r_state <= S_DONE;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - DC_W'(1);
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Loop counters: ig inner, og outer, op = og*num_ig + ig, pixel count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ig  <= {IG_W{1'b0}};
            r_og  <= {OG_W{1'b0}};
            r_pix <= {PIX_W{1'b0}};
            r_op  <= {ADDR_W{1'b0}};
        end else if ((r_state == S_IDLE) && start) begin
            r_ig  <= {IG_W{1'b0}};
            r_og  <= {OG_W{1'b0}};
            r_pix <= {PIX_W{1'b0}};
            r_op  <= {ADDR_W{1'b0}};
        end else if (w_issue) begin
            if (w_ig_wrap) begin
                r_ig <= {IG_W{1'b0}};
                if (w_og_wrap) begin
                    r_og  <= {OG_W{1'b0}};
                    r_op  <= {ADDR_W{1'b0}};
                    r_pix <= r_pix + PIX_W'(1);
                end else begin
                    r_og <= r_og + OG_W'(1);
                    r_op <= r_op + ADDR_W'(1);
                end
            end else begin
                r_ig <= r_ig + IG_W'(1);
                r_op <= r_op + ADDR_W'(1);
            end
        end
    end

    // Multiply-cycle controls, one cycle behind the weight read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mult_en <= 1'b0;
            r_fm_sel  <= {IG_W{1'b0}};
            r_win_pop <= 1'b0;
        end else begin
            r_mult_en <= w_issue;
            // Pop alongside the pixel's last multiply so the window is still valid for it.
            r_win_pop <= w_issue && w_ig_wrap && w_og_wrap;
            if (w_issue) begin
                r_fm_sel <= r_ig;
            end
        end
    end

    // Free-running tag shift register; never stalls, so tags cannot reorder.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_tag_vld[i] <= 1'b0;
                r_tag_dat[i] <= {TAG_W{1'b0}};
            end
        end else begin
            r_tag_vld[0] <= w_issue;
            r_tag_dat[0] <= w_tag_new;
            for (int i = 1; i < DEPTH; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag_dat[i] <= r_tag_dat[i-1];
            end
        end
    end

`ifdef CONV_MULT_SCHED_PERF_EN
    logic [31:0] r_perf_busy;
    logic [31:0] r_perf_stall;

    // Performance counters: cleared on an accepted start, hold after the pass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_busy  <= 32'd0;
            r_perf_stall <= 32'd0;
        end else if ((r_state == S_IDLE) && start) begin
            r_perf_busy  <= 32'd0;
            r_perf_stall <= 32'd0;
        end else begin
            if (r_state != S_IDLE) begin
                r_perf_busy <= r_perf_busy + 32'd1;
            end
            if ((r_state == S_RUN) && !w_issue) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_busy_cyc  = r_perf_busy;
    assign perf_stall_cyc = r_perf_stall;
`endif

    assign busy          = (r_state != S_IDLE);
    assign done          = (r_state == S_DONE);
    assign w_rd_en       = w_issue;
    assign w_addr        = r_op;
    assign mult_array_en = r_mult_en;
    assign fm_grp_sel    = r_fm_sel;
    assign win_pop       = r_win_pop;
    assign tag_valid     = r_tag_vld[DEPTH-1];
    assign acc_first     = r_tag_dat[DEPTH-1][TAG_W-1];
    assign acc_last      = r_tag_dat[DEPTH-1][TAG_W-2];
    assign acc_pix_last  = r_tag_dat[DEPTH-1][TAG_W-3];
    assign acc_og        = r_tag_dat[DEPTH-1][OG_W-1:0];

endmodule

// File: tb/tb_conv_mult_sched.sv
// Scoreboard bench for conv_mult_sched: two instances (PIPELINE_STAGE 1 and 3)
// exercised one at a time; stimulus pushes expected ops, a negedge monitor
// pops and compares on w_rd_en, mult_array_en, tag_valid and done.
module tb_conv_mult_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a [2];
    logic [7:0]  cfg_num_ig;
    logic [7:0]  cfg_num_og;
    logic [15:0] cfg_num_pix;
    logic        win_valid;
    logic        acc_stall;

    logic        busy_a [2];
    logic        done_a [2];
    logic        win_pop_a [2];
    logic [7:0]  fm_sel_a [2];
    logic        w_rd_en_a [2];
    logic [15:0] w_addr_a [2];
    logic        mult_en_a [2];
    logic        tag_valid_a [2];
    logic        acc_first_a [2];
    logic        acc_last_a [2];
    logic [7:0]  acc_og_a [2];
    logic        acc_pix_last_a [2];
`ifdef CONV_MULT_SCHED_PERF_EN
    logic [31:0] perf_busy_a [2];
    logic [31:0] perf_stall_a [2];
`endif

    always #5 clk = ~clk;

    conv_mult_sched #(.PIPELINE_STAGE(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_a[0]),
        .cfg_num_ig(cfg_num_ig), .cfg_num_og(cfg_num_og), .cfg_num_pix(cfg_num_pix),
        .busy(busy_a[0]), .done(done_a[0]), .win_valid(win_valid), .win_pop(win_pop_a[0]),
        .fm_grp_sel(fm_sel_a[0]), .w_rd_en(w_rd_en_a[0]), .w_addr(w_addr_a[0]),
        .mult_array_en(mult_en_a[0]), .acc_stall(acc_stall), .tag_valid(tag_valid_a[0]),
        .acc_first(acc_first_a[0]), .acc_last(acc_last_a[0]), .acc_og(acc_og_a[0]),
        .acc_pix_last(acc_pix_last_a[0])
`ifdef CONV_MULT_SCHED_PERF_EN
        , .perf_busy_cyc(perf_busy_a[0]), .perf_stall_cyc(perf_stall_a[0])
`endif
    );

    conv_mult_sched #(.PIPELINE_STAGE(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start_a[1]),
        .cfg_num_ig(cfg_num_ig), .cfg_num_og(cfg_num_og), .cfg_num_pix(cfg_num_pix),
        .busy(busy_a[1]), .done(done_a[1]), .win_valid(win_valid), .win_pop(win_pop_a[1]),
        .fm_grp_sel(fm_sel_a[1]), .w_rd_en(w_rd_en_a[1]), .w_addr(w_addr_a[1]),
        .mult_array_en(mult_en_a[1]), .acc_stall(acc_stall), .tag_valid(tag_valid_a[1]),
        .acc_first(acc_first_a[1]), .acc_last(acc_last_a[1]), .acc_og(acc_og_a[1]),
        .acc_pix_last(acc_pix_last_a[1])
`ifdef CONV_MULT_SCHED_PERF_EN
        , .perf_busy_cyc(perf_busy_a[1]), .perf_stall_cyc(perf_stall_a[1])
`endif
    );

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  ig;
        logic [7:0]  og;
        logic        first;
        logic        last;
        logic        pixlast;
        logic        pop;
    } op_t;

    op_t q_iss [$];
    op_t q_mul [$];
    op_t q_tag [$];
    int  q_cm [$];
    int  q_ct [$];

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;
    int act = 0;
    int start_cyc = 0;
    int last_iss = 0;
    int n_iss = 0;
    int n_pop = 0;
    bit zero_pass = 1'b0;
    bit done_seen = 1'b0;

    function automatic int ps_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function void chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, a, e, cyc);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: tags, then multiplies, then issues, then done.
    always @(negedge clk) begin
        op_t e;
        int  c;
        if (!rst) begin
            if (tag_valid_a[act]) begin
                if (q_tag.size() == 0 || q_ct.size() == 0) chk("tag_unexpected", 32'd1, 32'd0);
                else begin
                    e = q_tag.pop_front();
                    c = q_ct.pop_front();
                    chk("acc_first", 32'(acc_first_a[act]), 32'(e.first));
                    chk("acc_last", 32'(acc_last_a[act]), 32'(e.last));
                    chk("acc_og", 32'(acc_og_a[act]), 32'(e.og));
                    chk("acc_pix_last", 32'(acc_pix_last_a[act]), 32'(e.pixlast));
                    chk("tag_latency", 32'(cyc - c), 32'(ps_of(act) + 1));
                end
            end
            if (win_pop_a[act] && !mult_en_a[act]) chk("pop_without_mul", 32'd1, 32'd0);
            if (mult_en_a[act]) begin
                if (q_mul.size() == 0 || q_cm.size() == 0) chk("mul_unexpected", 32'd1, 32'd0);
                else begin
                    e = q_mul.pop_front();
                    c = q_cm.pop_front();
                    chk("fm_grp_sel", 32'(fm_sel_a[act]), 32'(e.ig));
                    chk("win_pop", 32'(win_pop_a[act]), 32'(e.pop));
                    chk("mul_latency", 32'(cyc - c), 32'd1);
                end
                if (win_pop_a[act]) n_pop++;
            end
            if (w_rd_en_a[act]) begin
                if (!win_valid || acc_stall) chk("issue_while_blocked", 32'd1, 32'd0);
                if (q_iss.size() == 0) chk("issue_unexpected", 32'd1, 32'd0);
                else begin
                    e = q_iss.pop_front();
                    chk("w_addr", 32'(w_addr_a[act]), 32'(e.addr));
                end
                q_cm.push_back(cyc);
                q_ct.push_back(cyc);
                last_iss = cyc;
                n_iss++;
            end
            if (done_a[act]) begin
                chk("done_latency", 32'(cyc - (zero_pass ? start_cyc : last_iss)),
                    32'(zero_pass ? 1 : ps_of(act) + 2));
                done_seen = 1'b1;
            end
        end
    end

    task automatic push_model(input int ig, input int og, input int pix);
        op_t e;
        for (int p = 0; p < pix; p++)
            for (int o = 0; o < og; o++)
                for (int i = 0; i < ig; i++) begin
                    e.addr    = 16'(o * ig + i);
                    e.ig      = 8'(i);
                    e.og      = 8'(o);
                    e.first   = (i == 0);
                    e.last    = (i == ig - 1);
                    e.pixlast = (p == pix - 1);
                    e.pop     = (i == ig - 1) && (o == og - 1);
                    q_iss.push_back(e);
                    q_mul.push_back(e);
                    q_tag.push_back(e);
                end
    endtask

    task automatic flush_sb();
        q_iss.delete();
        q_mul.delete();
        q_tag.delete();
        q_cm.delete();
        q_ct.delete();
    endtask

    task automatic kick(input int k, input int ig, input int og, input int pix);
        act       = k;
        n_iss     = 0;
        n_pop     = 0;
        done_seen = 1'b0;
        zero_pass = (ig == 0) || (og == 0) || (pix == 0);
        push_model(ig, og, pix);
        @(posedge clk); #1;
        cfg_num_ig  = 8'(ig);
        cfg_num_og  = 8'(og);
        cfg_num_pix = 16'(pix);
        start_a[k]  = 1'b1;
        start_cyc   = cyc;
    endtask

    // Stall windows are cycle offsets from the start cycle; exp_last is the
    // offset of the final issue (0 = none expected).
    task automatic run_pass(input int k, input int ig, input int og, input int pix,
                            input int s_from, input int s_len,
                            input int v_from, input int v_len, input int exp_last);
        kick(k, ig, og, pix);
        for (int n = 1; n <= 300 && !done_seen; n++) begin
            @(posedge clk); #1;
            start_a[k] = 1'b0;
            acc_stall  = (n >= s_from) && (n < s_from + s_len);
            win_valid  = !((n >= v_from) && (n < v_from + v_len));
            if (n == 1) chk("busy_after_start", 32'(busy_a[k]), 32'd1);
        end
        if (!done_seen) chk("done_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        acc_stall = 1'b0;
        win_valid = 1'b1;
        chk("done_one_cycle", 32'(done_a[k]), 32'd0);
        chk("busy_idle", 32'(busy_a[k]), 32'd0);
        chk("ops_left", 32'(q_iss.size() + q_mul.size() + q_tag.size()), 32'd0);
        chk("ops_issued", 32'(n_iss), 32'(ig * og * pix));
        chk("pop_count", 32'(n_pop), 32'(pix));
        if (exp_last > 0) chk("last_issue_offset", 32'(last_iss - start_cyc), 32'(exp_last));
    endtask

    initial begin
        rst         = 1'b1;
        start_a[0]  = 1'b0;
        start_a[1]  = 1'b0;
        cfg_num_ig  = 8'd0;
        cfg_num_og  = 8'd0;
        cfg_num_pix = 16'd0;
        win_valid   = 1'b1;
        acc_stall   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy_a[0]), 32'd0);
        chk("rst_done", 32'(done_a[0]), 32'd0);
        chk("rst_w_addr", 32'(w_addr_a[0]), 32'd0);
        chk("rst_tag_valid", 32'(tag_valid_a[1]), 32'd0);
        rst = 1'b0;

        // Plain pass: 12 back-to-back issues.
        run_pass(0, 2, 3, 2, 0, 0, 0, 0, 12);
        // acc_stall for 3 cycles after op 2.
        run_pass(0, 2, 3, 2, 3, 3, 0, 0, 15);
        // win_valid low for 5 cycles at the pixel boundary.
        run_pass(0, 2, 3, 2, 0, 0, 7, 5, 17);
        // Zero pixel count: straight to done, nothing issued.
        run_pass(0, 2, 3, 0, 0, 0, 0, 0, 0);

        // Reset in the middle of a pass after op 4.
        kick(0, 2, 3, 2);
        for (int n = 0; n < 50 && n_iss < 4; n++) begin
            @(posedge clk); #1;
            start_a[0] = 1'b0;
        end
        chk("ops_before_rst", 32'(n_iss), 32'd4);
        rst = 1'b1;
        #1;
        chk("rst_mid_w_rd_en", 32'(w_rd_en_a[0]), 32'd0);
        chk("rst_mid_mult_en", 32'(mult_en_a[0]), 32'd0);
        chk("rst_mid_tag_valid", 32'(tag_valid_a[0]), 32'd0);
        chk("rst_mid_busy", 32'(busy_a[0]), 32'd0);
        chk("rst_mid_w_addr", 32'(w_addr_a[0]), 32'd0);
        chk("rst_mid_fm_grp_sel", 32'(fm_sel_a[0]), 32'd0);
        flush_sb();
        @(posedge clk); #1;
        rst = 1'b0;
        run_pass(0, 1, 1, 1, 0, 0, 0, 0, 1);

        // Deeper array: PIPELINE_STAGE=3, two win_valid-low RUN cycles.
        run_pass(1, 1, 1, 4, 0, 0, 2, 2, 6);
`ifdef CONV_MULT_SCHED_PERF_EN
        chk("perf_stall_cyc", perf_stall_a[1], 32'd2);
        chk("perf_busy_cyc", perf_busy_a[1], 32'd11);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
